// File: rtl/fifo_packetizer_if.sv
// Bundle of the FIFO read port and the framed byte stream around fifo_packetizer.
// master = the packetizer itself, slave = FIFO and downstream transmitter side.
interface fifo_packetizer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_rget;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;

  modport master (
    input  fifo_dout, fifo_empty, tx_ready,
    output fifo_rget, tx_data, tx_valid, busy
  );

  modport slave (
    output fifo_dout, fifo_empty, tx_ready,
    input  fifo_rget, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/fifo_packetizer.sv
// Drains a first-word-fall-through FIFO into a payload buffer and emits each batch
// as a frame SYNC, LEN, payload, CSUM on a valid/ready byte stream.
module fifo_packetizer #(
  parameter int         WIDTH       = 8,
  parameter int         MAX_PAYLOAD = 16,
  parameter int         TIMEOUT     = 64,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  fifo_packetizer_if.master  bus
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int BW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0]    MAX_CNT = 8'(MAX_PAYLOAD);
  localparam logic [IW-1:0] TO_CNT  = IW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_HDR     = 3'd2,
    S_LEN     = 3'd3,
    S_PAY     = 3'd4,
    S_CSUM    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [WIDTH-1:0] mem_q [MAX_PAYLOAD];
  logic [WIDTH-1:0] mem_d [MAX_PAYLOAD];
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             pop_s;
  logic             accept_s;

  assign pop_s    = !rst && (state_q == S_COLLECT) && !bus.fifo_empty && (cnt_q < MAX_CNT);
  assign accept_s = tx_valid_q && bus.tx_ready;

  assign bus.fifo_rget = pop_s;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= 8'd0;
      csum_q     <= 8'd0;
      idle_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      idle_q     <= idle_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      mem_q      <= mem_d;
    end
  end

  // A pop zeroes idle_d, so a byte arriving on the would-be timeout cycle cancels it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    idle_d  = idle_q;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = 8'd0;
        idx_d  = 8'd0;
        csum_d = 8'd0;
        idle_d = '0;
        if (!bus.fifo_empty) state_d = S_COLLECT;
        else                 state_d = S_IDLE;
      end
      S_COLLECT: begin
        if (pop_s) begin
          mem_d[cnt_q[BW-1:0]] = bus.fifo_dout;
          cnt_d  = cnt_q + 8'd1;
          csum_d = csum_q + bus.fifo_dout;
          idle_d = '0;
        end else if (bus.fifo_empty && (idle_q != TO_CNT)) begin
          idle_d = idle_q + IW'(1);
        end else begin
          idle_d = idle_q;
        end
        if ((cnt_d == MAX_CNT) || ((idle_d == TO_CNT) && (cnt_d != 8'd0))) state_d = S_HDR;
        else                                                               state_d = S_COLLECT;
      end
      S_HDR: begin
        if (accept_s) state_d = S_LEN;
        else          state_d = S_HDR;
      end
      S_LEN: begin
        idx_d = 8'd0;
        if (accept_s) state_d = S_PAY;
        else          state_d = S_LEN;
      end
      S_PAY: begin
        if (accept_s && (idx_q == cnt_q - 8'd1)) begin
          state_d = S_CSUM;
        end else if (accept_s) begin
          idx_d = idx_q + 8'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      S_CSUM: begin
        if (accept_s) state_d = S_IDLE;
        else          state_d = S_CSUM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs follow state_d, so a stalled beat recomputes the same byte every cycle.
  always_comb begin
    tx_valid_d = 1'b1;
    busy_d     = 1'b1;
    tx_data_d  = '0;
    case (state_d)
      S_IDLE: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
      S_COLLECT: tx_valid_d = 1'b0;
      S_HDR:     tx_data_d  = SYNC_BYTE;
      S_LEN:     tx_data_d  = cnt_q;
      S_PAY:     tx_data_d  = mem_q[idx_d[BW-1:0]];
      S_CSUM:    tx_data_d  = 8'd0 - (cnt_q + csum_q);
      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_packetizer.sv
// Randomised and directed bench for fifo_packetizer against a queue-level frame model.
module tb_fifo_packetizer;
  localparam int MAXP = 4;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_packetizer_if bus ();

  fifo_packetizer #(
    .WIDTH(8), .MAX_PAYLOAD(MAXP), .TIMEOUT(TO), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  byte unsigned fq[$];
  byte unsigned acc_log[$];
  byte unsigned exp_q[$];
  byte unsigned m_pay[$];
  byte unsigned m_frm[$];
  int  m_mode = 0;
  int  m_idle = 0;
  int  m_sum;
  bit  exp_rget;
  bit  pop_pend = 1'b0;
  bit  rand_ready = 1'b0;
  bit  prev_hold = 1'b0;
  byte unsigned prev_data;
  int  rget_hits = 0;
  int  k, cyc, blen, gap, sent, total, pos;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_dout  = (fq.size() == 0) ? 8'h00 : fq[0];
  endfunction

  task automatic tick(input bit push, input logic [7:0] val);
    @(posedge clk);
    #1;
    if (pop_pend && fq.size() > 0) void'(fq.pop_front());
    if (push) fq.push_back(val);
    if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
    refresh();
  endtask

  task automatic wait_idle(input string name, input int budget);
    k = 0;
    while ((m_mode != 0 || fq.size() != 0) && k < budget) begin
      tick(1'b0, 8'h00);
      k++;
    end
    chk({name, "_drain_bound"}, int'(k < budget), 1);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, acc_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < acc_log.size()) chk($sformatf("%s_byte%0d", name, i), acc_log[i], exp_q[i]);
    end
  endtask

  // Cycle model: compare current outputs, then advance by what the next edge will do.
  always @(negedge clk) begin
    chk("tx_valid", bus.tx_valid, int'(m_mode == 2));
    chk("busy", bus.busy, int'(m_mode != 0));
    if (m_mode == 2 && m_frm.size() > 0) chk("tx_data", bus.tx_data, m_frm[0]);
    if (prev_hold) chk("tx_data_hold", bus.tx_data, prev_data);
    exp_rget = !rst && (m_mode == 1) && !bus.fifo_empty && (m_pay.size() < MAXP);
    chk("fifo_rget", bus.fifo_rget, exp_rget);
    pop_pend  = bus.fifo_rget;
    if (bus.fifo_rget) rget_hits++;
    if (bus.tx_valid && bus.tx_ready) acc_log.push_back(bus.tx_data);
    prev_hold = bus.tx_valid && !bus.tx_ready && !rst;
    prev_data = bus.tx_data;
    if (rst) begin
      m_mode = 0;
      m_idle = 0;
      m_pay.delete();
      m_frm.delete();
    end else begin
      case (m_mode)
        0: if (!bus.fifo_empty) begin
          m_mode = 1;
          m_idle = 0;
          m_pay.delete();
        end
        1: begin
          if (exp_rget) begin
            m_pay.push_back(bus.fifo_dout);
            m_idle = 0;
          end else if (bus.fifo_empty && m_idle < TO) begin
            m_idle++;
          end
          if (m_pay.size() == MAXP || (!exp_rget && m_idle == TO && m_pay.size() > 0)) begin
            m_sum = m_pay.size();
            m_frm.delete();
            m_frm.push_back(8'hA5);
            m_frm.push_back(8'(m_pay.size()));
            foreach (m_pay[i]) begin
              m_frm.push_back(m_pay[i]);
              m_sum += m_pay[i];
            end
            m_frm.push_back(8'(-m_sum));
            m_mode = 2;
          end
        end
        2: if (bus.tx_ready) begin
          void'(m_frm.pop_front());
          if (m_frm.size() == 0) m_mode = 0;
        end
        default: m_mode = 0;
      endcase
    end
  end

  initial begin
    rst = 1'b1;
    bus.tx_ready = 1'b0;
    refresh();
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    chk("reset_tx_valid", bus.tx_valid, 0);
    chk("reset_tx_data", bus.tx_data, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rget", bus.fifo_rget, 0);
    rst = 1'b0;
    bus.tx_ready = 1'b1;

    // 1: short batch flushed by timeout
    acc_log.delete();
    tick(1'b1, 8'h01); tick(1'b1, 8'h02); tick(1'b1, 8'h03);
    wait_idle("t1", 400);
    exp_q = {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    chk_log("t1");
    chk("t1_busy_after", bus.busy, 0);

    // 2: full frame at MAX_PAYLOAD, remainder after timeout
    acc_log.delete();
    for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h10 + i));
    wait_idle("t2", 600);
    exp_q = {8'hA5, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'hB6, 8'hA5, 8'h02, 8'h14, 8'h15, 8'hD5};
    chk_log("t2");

    // 3: same stream with a random ready
    acc_log.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h10 + i));
    wait_idle("t3", 800);
    chk_log("t3");
    rand_ready = 1'b0;
    bus.tx_ready = 1'b1;

    // 4: reset while the second payload byte is presented
    acc_log.delete();
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h30 + i));
    k = 0;
    while (acc_log.size() < 3 && k < 200) begin
      tick(1'b0, 8'h00);
      k++;
    end
    chk("t4_reach_pay", int'(k < 200), 1);
    rst = 1'b1;
    tick(1'b0, 8'h00);
    chk("t4_valid_after_rst", bus.tx_valid, 0);
    rst = 1'b0;
    acc_log.delete();
    tick(1'b1, 8'h40); tick(1'b1, 8'h41);
    wait_idle("t4", 400);
    exp_q = {8'hA5, 8'h02, 8'h40, 8'h41, 8'h7D};
    chk_log("t4");

    // 5: FIFO stays empty
    rget_hits = 0;
    repeat (1000) tick(1'b0, 8'h00);
    chk("t5_rget_hits", rget_hits, 0);
    chk("t5_valid", bus.tx_valid, 0);
    chk("t5_busy", bus.busy, 0);

    // 6: second byte arrives on the last cycle before timeout
    acc_log.delete();
    tick(1'b1, 8'h20);
    repeat (64) tick(1'b0, 8'h00);
    tick(1'b1, 8'h21);
    wait_idle("t6", 400);
    exp_q = {8'hA5, 8'h02, 8'h20, 8'h21, 8'hBD};
    chk_log("t6");

    // random bursts and gaps around the timeout, random ready
    acc_log.delete();
    rand_ready = 1'b1;
    cyc = 0;
    sent = 0;
    while (cyc < 3000) begin
      blen = $urandom_range(1, 8);
      gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 90) : $urandom_range(0, 20);
      for (int i = 0; i < blen; i++) begin
        tick(1'b1, 8'($urandom));
        sent++;
        cyc++;
      end
      for (int i = 0; i < gap; i++) begin
        tick(1'b0, 8'h00);
        cyc++;
      end
    end
    wait_idle("rand", 20000);
    total = 0;
    pos = 0;
    while (pos + 1 < acc_log.size()) begin
      total += acc_log[pos + 1];
      pos += acc_log[pos + 1] + 3;
    end
    chk("rand_payload_bytes", total, sent);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
